sha1_block_ctrl: RTL and testbench
==================================

# sha1_block_ctrl

Sequencing controller for the SHA-1 compression datapath (round functions f0–f3, rotate-by-1/5/30, 32-bit adders, w_expand). It accepts one 512-bit message block as 16 big-endian 32-bit words over a valid/ready stream and stores them in a 16-entry circular message-schedule buffer. It then runs the 80 rounds at one round per cycle and adds the working variables into the chaining state. The 160-bit digest is presented on a valid/ready output. Padding is done upstream; this block consumes already-padded blocks only.

## Interface
- No parameters. IV constants: H0=67452301, H1=EFCDAB89, H2=98BADCFE, H3=10325476, H4=C3D2E1F0. K: 5A827999, 6ED9EBA1, 8F1BBCDC, CA62C1D6.
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- msg_valid  in  1  msg_word valid
- msg_ready  out  1  block can accept a word this cycle
- msg_word  in  32  message word W[i], i=0..15, W[0] first
- init  in  1  sampled with word 0 of a block; 1 = start from IV (only meaningful with SHA1_CHAIN_EN)
- digest_valid  out  1  digest holds a finished result
- digest_ready  in  1  consumer accepts digest
- digest  out  160  {H0,H1,H2,H3,H4}, H0 in [159:128]
- busy  out  1  high whenever a block is in progress (wcnt≠0 or state≠LOAD)

## Operation
- State machine: LOAD, ROUND, FINAL, DONE. Reset state LOAD.
- LOAD:
  - msg_ready=1. Each msg_valid&&msg_ready writes buf[wcnt] and increments the 4-bit wcnt.
  - Gaps in msg_valid stall without penalty.
  - On acceptance of word 15: go to ROUND, t=0, wcnt wraps to 0. Latch A..E from the chaining regs (or from IV, see Configuration).
- ROUND (t=0..79, one round per cycle):
  - Wt = buf[t] for t<16.
  - For t≥16: Wt = rotl1(buf[(t-3)&15] ^ buf[(t-8)&15] ^ buf[(t-14)&15] ^ buf[t&15]), written back to buf[t&15] in the same cycle.
  - f and K by range: 0–19 f0 (Ch) with K0; 20–39 parity with K1; 40–59 f2 (Maj) with K2; 60–79 parity with K3.
  - temp = rotl5(A)+f+E+K+Wt, mod 2^32. E←D, D←C, C←rotl30(B), B←A, A←temp.
  - At t=79: go to FINAL.
- FINAL (1 cycle): Hi ← Hi + working var, each mod 2^32, no carry between words. Then go to DONE.
- DONE:
  - digest_valid=1. digest stable until digest_valid&&digest_ready.
  - On handshake: go to LOAD. msg_ready=1 from the next cycle.
- msg_ready=0 in ROUND, FINAL and DONE. msg_valid in those states is ignored and no word is consumed.
- digest output always reflects the chaining regs. It is only meaningful while digest_valid=1.

## Timing
- Reset values: msg_ready=1, digest_valid=0, busy=0, wcnt=0, t=0, chaining regs=IV (digest=IV), buffer contents don't-care.
- Contiguous load, words accepted on cycles 0..15:
  - rounds run on cycles 16..95
  - FINAL on cycle 96
  - digest_valid first high on cycle 97
  - latency is 97 cycles from first word to digest_valid
- With digest_ready tied high: digest_valid is a 1-cycle pulse and the next word 0 can be accepted on cycle 98.
- Back-pressure: digest_valid held indefinitely while digest_ready=0. No new block is accepted meanwhile.
- rst_n low in any state:
  - next state LOAD, all outputs and counters to reset values
  - a partially loaded or in-round block is discarded
- Round counter is 7-bit and never exceeds 79. Buffer index is always mod 16.

## Configuration
- SHA1_CHAIN_EN:
  - Defined: chaining regs persist across blocks for multi-block messages. A block whose word 0 is accepted with init=1 starts from IV. With init=0 it starts from the previous digest.
  - Undefined: every block starts from IV, init is ignored, and each block is an independent single-block hash.

## Test plan
- Empty message: block 80000000, 14×00000000, 00000000 -> digest da39a3ee5e6b4b0d3255bfef95601890afd80709, digest_valid on cycle 97.
- "abc": block 61626380, 14×0, 00000018, with msg_valid randomly deasserted 50% -> same digest a9993e364706816aba3e25717850c26c9cd0d89d. digest_valid arrives 97 cycles after the first word plus the stall cycles.
- Back-pressure: hold digest_ready=0 for 20 cycles in DONE while driving msg_valid=1 -> digest stable, msg_ready=0, no word consumed. Release -> LOAD next cycle.
- Mid-round reset: assert rst_n=0 at t=40, then load "abc" -> correct abc digest; outputs at reset values the cycle after reset.
- SHA1_CHAIN_EN: two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (block 1 init=1, block 2 init=0) -> digest matches the software SHA-1 model. Repeat block 2 with init=1 -> digest equals the single-block hash of block 2 from IV.
- Codebase test vector: block 61616262, 80000000, 13×0, 00000020 ("aabb") -> digest matches the software model. busy high from word 0 until the digest handshake.

Source files
------------

// File: rtl/sha1_block_ctrl.sv
// sha1_block_ctrl: SHA-1 block sequencer (16-word load, 80 rounds, chaining add, digest handshake).
// Optional multi-block chaining is enabled with `define SHA1_CHAIN_EN.
`default_nettype none

module sha1_block_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [31:0]  msg_word,
    input  logic         init,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [159:0] digest,
    output logic         busy
);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    localparam logic [31:0]  K0 = 32'h5A827999;
    localparam logic [31:0]  K1 = 32'h6ED9EBA1;
    localparam logic [31:0]  K2 = 32'h8F1BBCDC;
    localparam logic [31:0]  K3 = 32'hCA62C1D6;

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    function automatic logic [31:0] rotl5(input logic [31:0] x);
        return {x[26:0], x[31:27]};
    endfunction

    function automatic logic [31:0] rotl30(input logic [31:0] x);
        return {x[1:0], x[31:2]};
    endfunction

    logic [1:0]        state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [6:0]        t_q, t_d;
    logic [31:0]       a_q, b_q, c_q, d_q, e_q;
    logic [31:0]       a_d, b_d, c_d, d_d, e_d;
    logic [0:4][31:0]  h_q, h_d;
    logic [31:0]       sched_q [16];

    logic              w_buf_we;
    logic [3:0]        w_buf_addr;
    logic [31:0]       w_buf_wdata;
    logic              w_from_iv;
    logic [3:0]        w_idx, w_idx3, w_idx8, w_idx14;
    logic [31:0]       w_sched, w_wt, w_f, w_k, w_temp;

`ifdef SHA1_CHAIN_EN
    logic              init_q, init_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_q <= 1'b0;
        end else begin
            init_q <= init_d;
        end
    end

    always_comb begin
        init_d = init_q;
        if (state_q == S_LOAD && msg_valid && wcnt_q == 4'd0) begin
            init_d = init;
        end
    end

    assign w_from_iv = init_q;
`else
    logic              w_unused_init;

    assign w_unused_init = init;
    assign w_from_iv     = 1'b1;
`endif

    // Circular schedule: indices wrap mod 16, and W[t] overwrites the slot of W[t-16].
    assign w_idx   = t_q[3:0];
    assign w_idx3  = w_idx - 4'd3;
    assign w_idx8  = w_idx - 4'd8;
    assign w_idx14 = w_idx - 4'd14;
    assign w_sched = rotl1(sched_q[w_idx3] ^ sched_q[w_idx8] ^ sched_q[w_idx14] ^ sched_q[w_idx]);
    assign w_wt    = (t_q < 7'd16) ? sched_q[w_idx] : w_sched;

    always_comb begin
        if (t_q < 7'd20) begin
            w_f = (b_q & c_q) | (~b_q & d_q);
            w_k = K0;
        end else if (t_q < 7'd40) begin
            w_f = b_q ^ c_q ^ d_q;
            w_k = K1;
        end else if (t_q < 7'd60) begin
            w_f = (b_q & c_q) | (b_q & d_q) | (c_q & d_q);
            w_k = K2;
        end else begin
            w_f = b_q ^ c_q ^ d_q;
            w_k = K3;
        end
    end

    assign w_temp = rotl5(a_q) + w_f + e_q + w_k + w_wt;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        t_d         = t_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        d_d         = d_q;
        e_d         = e_q;
        h_d         = h_q;
        w_buf_we    = 1'b0;
        w_buf_addr  = wcnt_q;
        w_buf_wdata = msg_word;
        case (state_q)
            S_LOAD: begin
                if (msg_valid) begin
                    w_buf_we = 1'b1;
                    wcnt_d   = wcnt_q + 4'd1;
                    if (wcnt_q == 4'd15) begin
                        state_d = S_ROUND;
                        t_d     = 7'd0;
                        // Starting from IV also resets the chaining regs so FINAL adds IV.
                        if (w_from_iv) begin
                            h_d = IV;
                            {a_d, b_d, c_d, d_d, e_d} = IV;
                        end else begin
                            {a_d, b_d, c_d, d_d, e_d} = h_q;
                        end
                    end
                end
            end
            S_ROUND: begin
                a_d = w_temp;
                b_d = a_q;
                c_d = rotl30(b_q);
                d_d = c_q;
                e_d = d_q;
                if (t_q >= 7'd16) begin
                    w_buf_we    = 1'b1;
                    w_buf_addr  = w_idx;
                    w_buf_wdata = w_sched;
                end
                if (t_q == 7'd79) begin
                    state_d = S_FINAL;
                    t_d     = 7'd0;
                end else begin
                    t_d = t_q + 7'd1;
                end
            end
            S_FINAL: begin
                h_d[0]  = h_q[0] + a_q;
                h_d[1]  = h_q[1] + b_q;
                h_d[2]  = h_q[2] + c_q;
                h_d[3]  = h_q[3] + d_q;
                h_d[4]  = h_q[4] + e_q;
                state_d = S_DONE;
            end
            default: begin
                if (digest_ready) begin
                    state_d = S_LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            wcnt_q  <= 4'd0;
            t_q     <= 7'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            c_q     <= 32'd0;
            d_q     <= 32'd0;
            e_q     <= 32'd0;
            h_q     <= IV;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            t_q     <= t_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            e_q     <= e_d;
            h_q     <= h_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            sched_q[w_buf_addr] <= w_buf_wdata;
        end
    end

    assign msg_ready    = (state_q == S_LOAD);
    assign digest_valid = (state_q == S_DONE);
    assign digest       = h_q;
    assign busy         = (wcnt_q != 4'd0) || (state_q != S_LOAD);

endmodule

`default_nettype wire

// File: tb/tb_sha1_block_ctrl.sv
// Directed self-checking bench for sha1_block_ctrl; chained-block steps need `define SHA1_CHAIN_EN.
`default_nettype none

module tb_sha1_block_ctrl;

    localparam logic [159:0] IV      = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    localparam logic [159:0] D_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] D_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] D_TWO   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B_AABB  = {32'h61616262, 32'h80000000, 416'h0, 32'h00000020};
    localparam logic [511:0] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         msg_valid;
    logic         msg_ready;
    logic [31:0]  msg_word;
    logic         init;
    logic         digest_valid;
    logic         digest_ready;
    logic [159:0] digest;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int edges;
    int stalls;
    bit busy_ok;

    sha1_block_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .msg_word     (msg_word),
        .init         (init),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .digest       (digest),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [159:0] sha1_ref(input logic [159:0] hin, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp, x;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 80; t++) begin
            x    = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
            w[t] = {x[30:0], x[31]};
        end
        {a, b, c, d, e} = hin;
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
            e = d;
            d = c;
            c = {b[1:0], b[31:2]};
            b = a;
            a = tmp;
        end
        return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents the first n words; edges counts clock edges since word 0 was presented.
    task automatic load_words(input logic [511:0] b, input logic ini, input int n, input bit stall);
        edges   = 0;
        stalls  = 0;
        busy_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (stall) begin
                while ($urandom_range(0, 1) == 1) begin
                    msg_valid = 1'b0;
                    step();
                    if (i > 0) begin
                        edges++;
                        stalls++;
                        if (busy !== 1'b1) busy_ok = 1'b0;
                    end
                end
            end
            msg_valid = 1'b1;
            msg_word  = b[511 - 32*i -: 32];
            init      = ini;
            step();
            edges++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        msg_valid = 1'b0;
        msg_word  = 32'hA5A5A5A5;
        init      = 1'b0;
    endtask

    task automatic run_block(input string tag, input logic [511:0] b, input logic ini,
                             input bit stall, input logic [159:0] exp, input bit hold);
        load_words(b, ini, 16, stall);
        while (digest_valid !== 1'b1 && edges < 400) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            step();
            edges++;
        end
        chk({tag, " latency"}, 160'(edges), 160'(97 + stalls));
        chk({tag, " busy"}, {159'd0, busy_ok}, 160'd1);
        chk({tag, " digest"}, digest, exp);
        if (!hold) begin
            digest_ready = 1'b1;
            step();
            digest_ready = 1'b0;
            chk({tag, " back to load"}, {157'd0, msg_ready, digest_valid, busy}, 160'b100);
        end
    endtask

    initial begin
        bit stable_ok, ready_ok;
        rst_n        = 1'b0;
        msg_valid    = 1'b0;
        msg_word     = 32'd0;
        init         = 1'b0;
        digest_ready = 1'b0;
        step();
        step();
        chk("reset msg_ready", {159'd0, msg_ready}, 160'd1);
        chk("reset digest_valid", {159'd0, digest_valid}, 160'd0);
        chk("reset busy", {159'd0, busy}, 160'd0);
        chk("reset digest", digest, IV);
        rst_n = 1'b1;
        step();

        run_block("empty", B_EMPTY, 1'b1, 1'b0, D_EMPTY, 1'b0);
        run_block("abc stalled", B_ABC, 1'b1, 1'b1, D_ABC, 1'b0);
        run_block("aabb", B_AABB, 1'b1, 1'b0, sha1_ref(IV, B_AABB), 1'b0);

        // Back-pressure: digest held while words are offered and must not be consumed.
        run_block("bp", B_ABC, 1'b1, 1'b0, D_ABC, 1'b1);
        stable_ok    = 1'b1;
        ready_ok     = 1'b1;
        msg_valid    = 1'b1;
        msg_word     = 32'hDEADBEEF;
        for (int i = 0; i < 20; i++) begin
            step();
            if (digest !== D_ABC || digest_valid !== 1'b1) stable_ok = 1'b0;
            if (msg_ready !== 1'b0) ready_ok = 1'b0;
        end
        chk("bp digest stable", {159'd0, stable_ok}, 160'd1);
        chk("bp msg_ready low", {159'd0, ready_ok}, 160'd1);
        msg_valid    = 1'b0;
        digest_ready = 1'b1;
        step();
        digest_ready = 1'b0;
        chk("bp release load", {158'd0, msg_ready, digest_valid}, 160'b10);
        run_block("after bp", B_EMPTY, 1'b1, 1'b0, D_EMPTY, 1'b0);

        // Reset in the middle of the rounds, at t=40.
        load_words(B_AABB, 1'b1, 16, 1'b0);
        for (int i = 0; i < 40; i++) step();
        rst_n = 1'b0;
        step();
        chk("midround rst flags", {157'd0, msg_ready, digest_valid, busy}, 160'b100);
        chk("midround rst digest", digest, IV);
        rst_n = 1'b1;
        run_block("abc after rst", B_ABC, 1'b1, 1'b0, D_ABC, 1'b0);

        // Reset with a partially loaded block.
        load_words(B_AABB, 1'b1, 7, 1'b0);
        rst_n = 1'b0;
        step();
        chk("partial rst busy", {159'd0, busy}, 160'd0);
        rst_n = 1'b1;
        run_block("empty after partial", B_EMPTY, 1'b1, 1'b0, D_EMPTY, 1'b0);

`ifdef SHA1_CHAIN_EN
        run_block("chain blk1", B_TWO1, 1'b1, 1'b0, sha1_ref(IV, B_TWO1), 1'b0);
        run_block("chain blk2", B_TWO2, 1'b0, 1'b0, D_TWO, 1'b0);
        run_block("blk2 from iv", B_TWO2, 1'b1, 1'b0, sha1_ref(IV, B_TWO2), 1'b0);
`else
        run_block("blk1 alone", B_TWO1, 1'b1, 1'b0, sha1_ref(IV, B_TWO1), 1'b0);
        run_block("blk2 init0", B_TWO2, 1'b0, 1'b0, sha1_ref(IV, B_TWO2), 1'b0);
        run_block("abc init0", B_ABC, 1'b0, 1'b1, D_ABC, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
